// File: rtl/ecc_scrubber_pkg.sv
// ecc_scrubber_pkg
// Shared definitions for the ECC scrubber: word and check-bit widths, the
// syndrome thresholds that separate correctable from uncorrectable errors,
// the scrubber FSM state encoding, and the Hamming position helper used by
// the single-error-correct decoder.
package ecc_scrubber_pkg;

    localparam int DATA_W       = 32;
    localparam int PAR_W        = 6;
    localparam int SYN_W        = 6;
    // Highest codeword position; syndromes above this cannot name a bit.
    localparam int SYN_MAX_CORR = 38;
    // Largest value a 6-bit syndrome can take.
    localparam int SYN_MAX      = 63;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        CHECK   = 3'd3,
        WR_REQ  = 3'd4,
        GAP     = 3'd5,
        DONE    = 3'd6
    } state_t;

    // Codeword position of data bit idx. Data fills positions 3..38 in
    // ascending order, skipping the powers of two reserved for check bits.
    function automatic logic [SYN_W-1:0] data_pos(input int idx);
        int n;
        n        = 0;
        data_pos = '0;
        for (int p = 3; p <= SYN_MAX_CORR; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) begin
                    data_pos = SYN_W'(p);
                end
                n++;
            end
        end
    endfunction

endpackage

// File: rtl/ecc_scrubber_sec_decode.sv
// sec_decode
// Combinational Hamming single-error-correct decoder for a 32-bit word
// protected by 6 check bits.
// Ports:
//   data, parity         in   stored word and stored check bits
//   corr_data            out  data with a single flipped data bit repaired
//   corr_parity          out  check bits with a single flipped check bit repaired
//   syndrome             out  raw syndrome (0 = clean)
//   uncorrectable        out  syndrome does not name any codeword position
module sec_decode
    import ecc_scrubber_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  logic [PAR_W-1:0]  parity,
    output logic [DATA_W-1:0] corr_data,
    output logic [PAR_W-1:0]  corr_parity,
    output logic [SYN_W-1:0]  syndrome,
    output logic              uncorrectable
);

    // Each set data bit contributes its codeword position to the syndrome;
    // the stored check bits seed the accumulation.
    always_comb begin
        syndrome = parity;
        for (int i = 0; i < DATA_W; i++) begin
            if (data[i]) begin
                syndrome = syndrome ^ data_pos(i);
            end
        end
    end

    // A power-of-two syndrome points at a check bit, any other value up to
    // the top codeword position points at a data bit, and the rest cannot
    // be repaired.
    always_comb begin
        corr_data     = data;
        corr_parity   = parity;
        uncorrectable = 1'b0;
        if (int'(syndrome) > SYN_MAX_CORR && int'(syndrome) <= SYN_MAX) begin
            uncorrectable = 1'b1;
        end else if (syndrome != '0) begin
            if ((syndrome & (syndrome - SYN_W'(1))) == '0) begin
                for (int k = 0; k < PAR_W; k++) begin
                    if (syndrome == SYN_W'(1 << k)) begin
                        corr_parity[k] = ~parity[k];
                    end
                end
            end else begin
                for (int i = 0; i < DATA_W; i++) begin
                    if (data_pos(i) == syndrome) begin
                        corr_data[i] = ~data[i];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber
// Walks every word of a memory once per start pulse, reads it, checks it
// with a Hamming SEC decoder, writes back repaired words and counts errors.
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   start, interval                 begin a sweep; idle cycles between words
//   mem_req/we/addr/wdata/wpar      memory request channel (held until mem_gnt)
//   mem_gnt                         request accepted this cycle
//   mem_rvalid/rdata/rpar           read response
//   busy, done                      sweep in progress; end-of-sweep pulse
//   corr_count, unc_count           saturating per-sweep error counts
//   err_valid, err_addr, err_unc    per-error pulse and latest error details
module ecc_scrubber
    import ecc_scrubber_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int INTERVAL_W = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [INTERVAL_W-1:0] interval,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    output logic [PAR_W-1:0]      mem_wpar,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    input  logic [PAR_W-1:0]      mem_rpar,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           corr_count,
    output logic [15:0]           unc_count,
    output logic                  err_valid,
    output logic [ADDR_W-1:0]     err_addr,
    output logic                  err_unc
);

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q;
    logic [INTERVAL_W-1:0] interval_q;
    logic [INTERVAL_W-1:0] gap_cnt_q;
    logic [DATA_W-1:0]     rdata_q;
    logic [PAR_W-1:0]      rpar_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [PAR_W-1:0]      wpar_q;
    logic [15:0]           corr_q;
    logic [15:0]           unc_q;
    logic                  err_valid_q;
    logic [ADDR_W-1:0]     err_addr_q;
    logic                  err_unc_q;

    logic [DATA_W-1:0]     dec_data;
    logic [PAR_W-1:0]      dec_par;
    logic [SYN_W-1:0]      dec_syn;
    logic                  dec_unc;
    logic                  last_word;
    logic                  gap_expired;

    // The decoder only ever sees the registered word so CHECK has a full
    // cycle for the syndrome tree regardless of memory timing.
    sec_decode u_sec_decode (
        .data          (rdata_q),
        .parity        (rpar_q),
        .corr_data     (dec_data),
        .corr_parity   (dec_par),
        .syndrome      (dec_syn),
        .uncorrectable (dec_unc)
    );

    assign last_word   = (addr_q == {ADDR_W{1'b1}});
    assign gap_expired = (gap_cnt_q == '0);

    // Next-state logic. Requests wait for a grant, reads wait for rvalid,
    // and only a repairable error takes the write-back detour.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start)      state_d = RD_REQ;
            RD_REQ:  if (mem_gnt)    state_d = RD_WAIT;
            RD_WAIT: if (mem_rvalid) state_d = CHECK;
            CHECK: begin
                if (dec_syn == '0 || dec_unc) state_d = GAP;
                else                          state_d = WR_REQ;
            end
            WR_REQ:  if (mem_gnt)    state_d = GAP;
            GAP: begin
                if (gap_expired) state_d = last_word ? DONE : RD_REQ;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register plus datapath. Counters and error registers are only
    // cleared by reset or a new sweep, so software can read them after done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            interval_q  <= '0;
            gap_cnt_q   <= '0;
            rdata_q     <= '0;
            rpar_q      <= '0;
            wdata_q     <= '0;
            wpar_q      <= '0;
            corr_q      <= '0;
            unc_q       <= '0;
            err_valid_q <= 1'b0;
            err_addr_q  <= '0;
            err_unc_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            err_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        addr_q     <= '0;
                        corr_q     <= '0;
                        unc_q      <= '0;
                        interval_q <= interval;
                    end
                end
                RD_WAIT: begin
                    if (mem_rvalid) begin
                        rdata_q <= mem_rdata;
                        rpar_q  <= mem_rpar;
                    end
                end
                CHECK: begin
                    gap_cnt_q <= interval_q;
                    if (dec_syn != '0) begin
                        err_valid_q <= 1'b1;
                        err_addr_q  <= addr_q;
                        err_unc_q   <= dec_unc;
                        if (dec_unc) begin
                            if (unc_q != 16'hFFFF) unc_q <= unc_q + 16'd1;
                        end else begin
                            if (corr_q != 16'hFFFF) corr_q <= corr_q + 16'd1;
                            wdata_q <= dec_data;
                            wpar_q  <= dec_par;
                        end
                    end
                end
                GAP: begin
                    if (!gap_expired) begin
                        gap_cnt_q <= gap_cnt_q - INTERVAL_W'(1);
                    end else if (!last_word) begin
                        addr_q <= addr_q + ADDR_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req    = (state_q == RD_REQ) || (state_q == WR_REQ);
    assign mem_we     = (state_q == WR_REQ);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_wpar   = wpar_q;
    assign busy       = (state_q != IDLE);
    assign done       = (state_q == DONE);
    assign corr_count = corr_q;
    assign unc_count  = unc_q;
    assign err_valid  = err_valid_q;
    assign err_addr   = err_addr_q;
    assign err_unc    = err_unc_q;

endmodule

// File: tb/tb_ecc_scrubber.sv
// tb_ecc_scrubber
// Self-checking bench for ecc_scrubber with a 4-word memory model. Expected
// results come from a positional Hamming model: a word's syndrome is the XOR
// of the positions of all set codeword bits.
module tb_ecc_scrubber;

    localparam int ADDR_W     = 2;
    localparam int INTERVAL_W = 16;
    localparam int NWORDS     = 1 << ADDR_W;
    localparam int TIMEOUT    = 3000;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  start = 1'b0;
    logic [INTERVAL_W-1:0] interval = '0;
    logic                  mem_req, mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [31:0]           mem_wdata;
    logic [5:0]            mem_wpar;
    logic                  mem_gnt = 1'b0;
    logic                  mem_rvalid = 1'b0;
    logic [31:0]           mem_rdata = '0;
    logic [5:0]            mem_rpar = '0;
    logic                  busy, done;
    logic [15:0]           corr_count, unc_count;
    logic                  err_valid;
    logic [ADDR_W-1:0]     err_addr;
    logic                  err_unc;

    ecc_scrubber #(.ADDR_W(ADDR_W), .INTERVAL_W(INTERVAL_W)) dut (
        .clk(clk), .reset(reset), .start(start), .interval(interval),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wpar(mem_wpar), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_rpar(mem_rpar),
        .busy(busy), .done(done), .corr_count(corr_count), .unc_count(unc_count),
        .err_valid(err_valid), .err_addr(err_addr), .err_unc(err_unc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          addr;
        logic [31:0] d;
        logic [5:0]  p;
    } wr_t;

    int          n_checks = 0;
    int          n_fail = 0;
    int          pos_tab[32];
    logic [31:0] mem_data[NWORDS];
    logic [5:0]  mem_par[NWORDS];
    logic [31:0] gold_data[NWORDS];

    // responder configuration and observed traffic
    bit  gnt_random = 1'b0;
    int  lat_min = 1, lat_max = 1;
    int  stall_rd_left = 0, stall_wr_left = 0;
    int  pend_cnt = 0, pend_addr = 0;
    int  reads = 0, writes = 0, done_cnt = 0, errv_cnt = 0, busy_cycles = 0;
    int  read_addrs[$];
    wr_t wr_log[$];

    // model expectations
    int  exp_corr, exp_unc, exp_errs, exp_last_addr;
    bit  exp_last_unc;
    wr_t exp_wr[$];

    // Parity bit k covers every data bit whose codeword position has bit k set.
    function automatic logic [5:0] encode(input logic [31:0] d);
        logic [5:0] p;
        p = '0;
        for (int i = 0; i < 32; i++)
            for (int k = 0; k < 6; k++)
                if (d[i] && ((pos_tab[i] >> k) & 1) == 1) p[k] = ~p[k];
        return p;
    endfunction

    // Lay the word out as a 39-bit codeword and XOR the positions of set bits.
    function automatic int syndrome_of(input logic [31:0] d, input logic [5:0] p);
        logic [38:0] cw;
        int s;
        cw = '0;
        for (int k = 0; k < 6; k++) cw[1 << k] = p[k];
        for (int i = 0; i < 32; i++) cw[pos_tab[i]] = d[i];
        s = 0;
        for (int q = 1; q <= 38; q++) if (cw[q]) s = s ^ q;
        return s;
    endfunction

    // kind: 0 clean, 1 flip data bit arg, 2 flip check bit arg, 3 XOR check bits with arg
    task automatic set_word(input int w, input logic [31:0] d, input int kind, input int arg);
        gold_data[w] = d;
        mem_data[w]  = d;
        mem_par[w]   = encode(d);
        case (kind)
            1: mem_data[w][arg] = ~mem_data[w][arg];
            2: mem_par[w][arg]  = ~mem_par[w][arg];
            3: mem_par[w]       = mem_par[w] ^ 6'(arg);
            default: ;
        endcase
    endtask

    task automatic model_sweep();
        int  s;
        wr_t e;
        exp_corr = 0; exp_unc = 0; exp_errs = 0;
        exp_last_addr = 0; exp_last_unc = 1'b0;
        exp_wr.delete();
        for (int w = 0; w < NWORDS; w++) begin
            s = syndrome_of(mem_data[w], mem_par[w]);
            if (s != 0) begin
                exp_errs++;
                exp_last_addr = w;
                if (s > 38) begin
                    exp_unc++;
                    exp_last_unc = 1'b1;
                end else begin
                    exp_corr++;
                    exp_last_unc = 1'b0;
                    e.addr = w; e.d = gold_data[w]; e.p = encode(gold_data[w]);
                    exp_wr.push_back(e);
                end
            end
        end
    endtask

    // Memory responder: grants and read data change on the falling edge so
    // the DUT sees stable inputs at the rising edge.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = $urandom;
            mem_rpar   = 6'($urandom);
            if (reset) begin
                pend_cnt = 0;
            end else if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_data[pend_addr];
                    mem_rpar   = mem_par[pend_addr];
                end
            end
            if (mem_req && !mem_we && stall_rd_left > 0) begin
                mem_gnt = 1'b0; stall_rd_left--;
            end else if (mem_req && mem_we && stall_wr_left > 0) begin
                mem_gnt = 1'b0; stall_wr_left--;
            end else begin
                mem_gnt = gnt_random ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (mem_req && mem_gnt && !reset) begin
                if (mem_we) begin
                    e.addr = int'(mem_addr); e.d = mem_wdata; e.p = mem_wpar;
                    wr_log.push_back(e);
                    mem_data[mem_addr] = mem_wdata;
                    mem_par[mem_addr]  = mem_wpar;
                    writes++;
                end else begin
                    reads++;
                    read_addrs.push_back(int'(mem_addr));
                    pend_addr = int'(mem_addr);
                    pend_cnt  = $urandom_range(lat_min, lat_max);
                end
            end
            if (done === 1'b1)      done_cnt++;
            if (err_valid === 1'b1) errv_cnt++;
            if (busy === 1'b1)      busy_cycles++;
        end
    end

    task automatic clear_stats();
        reads = 0; writes = 0; done_cnt = 0; errv_cnt = 0; busy_cycles = 0;
        read_addrs.delete();
        wr_log.delete();
    endtask

    // Pulse start and wait (bounded) for done; optionally pulse start again mid-sweep.
    task automatic run_sweep(input int intv, input bit poke, output bit ok);
        clear_stats();
        @(negedge clk);
        start = 1'b1;
        interval = INTERVAL_W'(intv);
        @(negedge clk);
        start = 1'b0;
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT; n++) begin
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            start = (poke && n == 8);
            @(negedge clk);
        end
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({mem_req, mem_we, mem_addr, mem_wdata, mem_wpar, busy, done, corr_count,
             unc_count, err_valid, err_addr, err_unc} !== '0) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got req=%b we=%b addr=%0h wdata=%0h wpar=%0h busy=%b done=%b corr=%0d unc=%0d ev=%b ea=%0h eu=%b, expected all zero",
                     mem_req, mem_we, mem_addr, mem_wdata, mem_wpar, busy, done,
                     corr_count, unc_count, err_valid, err_addr, err_unc);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy);
        end
    endtask

    task automatic test_clean_sweep();
        bit ok;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        run_sweep(0, 1'b0, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("[TB] FAIL clean_timeout: done got 0 expected 1"); end
        n_checks++;
        if (reads !== 4 || writes !== 0) begin
            n_fail++; $display("[TB] FAIL clean_traffic: got reads=%0d writes=%0d expected 4/0", reads, writes);
        end
        for (int i = 0; i < read_addrs.size() && i < NWORDS; i++) begin
            n_checks++;
            if (read_addrs[i] !== i) begin
                n_fail++; $display("[TB] FAIL clean_read_order[%0d]: got %0d expected %0d", i, read_addrs[i], i);
            end
        end
        n_checks++;
        if (done_cnt !== 1 || errv_cnt !== 0) begin
            n_fail++; $display("[TB] FAIL clean_pulses: got done=%0d err_valid=%0d expected 1/0", done_cnt, errv_cnt);
        end
        n_checks++;
        if (corr_count !== 16'd0 || unc_count !== 16'd0) begin
            n_fail++; $display("[TB] FAIL clean_counts: got corr=%0d unc=%0d expected 0/0", corr_count, unc_count);
        end
        // read, wait, check and a one-cycle gap per word, plus the done cycle
        n_checks++;
        if (busy_cycles !== 4 * NWORDS + 1) begin
            n_fail++; $display("[TB] FAIL clean_busy_cycles: got %0d expected %0d", busy_cycles, 4 * NWORDS + 1);
        end
    endtask

    task automatic test_interval();
        bit ok;
        int intv;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        intv = $urandom_range(2, 5);
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        run_sweep(intv, 1'b0, ok);
        n_checks++;
        if (!ok || busy_cycles !== NWORDS * (4 + intv) + 1) begin
            n_fail++; $display("[TB] FAIL interval_busy_cycles: got %0d (done=%b) expected %0d",
                               busy_cycles, ok, NWORDS * (4 + intv) + 1);
        end
    endtask

    task automatic test_data_error();
        bit ok;
        gnt_random = 1'b0; lat_min = 1; lat_max = 2;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        set_word(1, 32'h0000_0001, 1, 0);
        run_sweep(1, 1'b1, ok);
        n_checks++;
        if (!ok || reads !== 4 || writes !== 1) begin
            n_fail++; $display("[TB] FAIL data_err_traffic: got done=%b reads=%0d writes=%0d expected 1/4/1", ok, reads, writes);
        end
        n_checks++;
        if (wr_log.size() != 1 || wr_log[0].addr !== 1 || wr_log[0].d !== 32'h0000_0001 || wr_log[0].p !== 6'h03) begin
            n_fail++;
            if (wr_log.size() == 0) $display("[TB] FAIL data_err_write: got no write expected addr=1 data=1 par=03");
            else $display("[TB] FAIL data_err_write: got addr=%0d data=%h par=%h expected addr=1 data=00000001 par=03",
                          wr_log[0].addr, wr_log[0].d, wr_log[0].p);
        end
        n_checks++;
        if (corr_count !== 16'd1 || unc_count !== 16'd0 || err_addr !== 2'd1 || err_unc !== 1'b0 || errv_cnt !== 1) begin
            n_fail++; $display("[TB] FAIL data_err_status: got corr=%0d unc=%0d ea=%0d eu=%b pulses=%0d expected 1/0/1/0/1",
                               corr_count, unc_count, err_addr, err_unc, errv_cnt);
        end
    endtask

    task automatic test_parity_error();
        bit ok;
        logic [31:0] d;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        d = $urandom;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        set_word(2, d, 2, 3);
        run_sweep(0, 1'b0, ok);
        n_checks++;
        if (!ok || writes !== 1 || wr_log.size() != 1) begin
            n_fail++; $display("[TB] FAIL par_err_traffic: got done=%b writes=%0d expected 1/1", ok, writes);
        end else begin
            n_checks++;
            if (wr_log[0].addr !== 2 || wr_log[0].d !== d || wr_log[0].p !== encode(d)) begin
                n_fail++; $display("[TB] FAIL par_err_write: got addr=%0d data=%h par=%h expected addr=2 data=%h par=%h",
                                   wr_log[0].addr, wr_log[0].d, wr_log[0].p, d, encode(d));
            end
        end
        n_checks++;
        if (corr_count !== 16'd1 || err_addr !== 2'd2 || err_unc !== 1'b0) begin
            n_fail++; $display("[TB] FAIL par_err_status: got corr=%0d ea=%0d eu=%b expected 1/2/0", corr_count, err_addr, err_unc);
        end
    endtask

    task automatic test_uncorrectable();
        bit ok;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        set_word(3, $urandom, 3, 45);
        run_sweep(0, 1'b0, ok);
        n_checks++;
        if (!ok || writes !== 0) begin
            n_fail++; $display("[TB] FAIL unc_no_write: got done=%b writes=%0d expected 1/0", ok, writes);
        end
        n_checks++;
        if (unc_count !== 16'd1 || corr_count !== 16'd0 || err_unc !== 1'b1 || err_addr !== 2'd3) begin
            n_fail++; $display("[TB] FAIL unc_status: got unc=%0d corr=%0d eu=%b ea=%0d expected 1/0/1/3",
                               unc_count, corr_count, err_unc, err_addr);
        end
    endtask

    task automatic test_stall();
        bit ok, rd_stable, wr_stable, saw_rd, saw_wr;
        logic [ADDR_W-1:0] a0;
        logic [31:0] d0;
        logic [5:0] p0;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        set_word(0, $urandom, 1, 5);
        stall_rd_left = 5; stall_wr_left = 5;
        clear_stats();
        @(negedge clk); start = 1'b1; interval = '0;
        @(negedge clk); start = 1'b0;
        saw_rd = 1'b0; rd_stable = 1'b1;
        for (int n = 0; n < 50 && !saw_rd; n++) begin
            if (mem_req === 1'b1) saw_rd = 1'b1; else @(negedge clk);
        end
        a0 = mem_addr;
        for (int n = 0; n < 6; n++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== a0) rd_stable = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!saw_rd || !rd_stable) begin
            n_fail++; $display("[TB] FAIL stall_read_hold: got seen=%b stable=%b expected 1/1", saw_rd, rd_stable);
        end
        saw_wr = 1'b0; wr_stable = 1'b1;
        for (int n = 0; n < 50 && !saw_wr; n++) begin
            if (mem_req === 1'b1 && mem_we === 1'b1) saw_wr = 1'b1; else @(negedge clk);
        end
        a0 = mem_addr; d0 = mem_wdata; p0 = mem_wpar;
        for (int n = 0; n < 6; n++) begin
            if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== a0 || mem_wdata !== d0 || mem_wpar !== p0)
                wr_stable = 1'b0;
            @(negedge clk);
        end
        n_checks++;
        if (!saw_wr || !wr_stable || d0 !== gold_data[0]) begin
            n_fail++; $display("[TB] FAIL stall_write_hold: got seen=%b stable=%b wdata=%h expected 1/1/%h",
                               saw_wr, wr_stable, d0, gold_data[0]);
        end
        ok = 1'b0;
        for (int n = 0; n < TIMEOUT && !ok; n++) begin
            if (done === 1'b1) ok = 1'b1; else @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (!ok || reads !== 4 || writes !== 1 || stall_rd_left !== 0 || stall_wr_left !== 0) begin
            n_fail++; $display("[TB] FAIL stall_transfers: got done=%b reads=%0d writes=%0d expected 1/4/1", ok, reads, writes);
        end
        stall_rd_left = 0; stall_wr_left = 0;
    endtask

    task automatic test_reset_mid_sweep();
        bit saw_wr;
        gnt_random = 1'b0; lat_min = 1; lat_max = 1;
        for (int w = 0; w < NWORDS; w++) set_word(w, $urandom, 0, 0);
        set_word(0, $urandom, 1, 17);
        stall_wr_left = 1000;
        clear_stats();
        @(negedge clk); start = 1'b1; interval = '0;
        @(negedge clk); start = 1'b0;
        saw_wr = 1'b0;
        for (int n = 0; n < 50 && !saw_wr; n++) begin
            if (mem_req === 1'b1 && mem_we === 1'b1) saw_wr = 1'b1; else @(negedge clk);
        end
        n_checks++;
        if (!saw_wr || corr_count !== 16'd1) begin
            n_fail++; $display("[TB] FAIL rst_reach_write: got seen=%b corr=%0d expected 1/1", saw_wr, corr_count);
        end
        reset = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({busy, mem_req, mem_we, done, err_valid, err_unc} !== 6'b0 || corr_count !== 16'd0 ||
            unc_count !== 16'd0 || err_addr !== '0 || mem_wdata !== '0 || mem_wpar !== '0 || mem_addr !== '0) begin
            n_fail++; $display("[TB] FAIL rst_mid_sweep: got busy=%b req=%b we=%b corr=%0d unc=%0d wdata=%h expected all zero",
                               busy, mem_req, mem_we, corr_count, unc_count, mem_wdata);
        end
        stall_wr_left = 0;
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_random_sweeps();
        bit ok;
        int kind;
        gnt_random = 1'b1; lat_min = 1; lat_max = 3;
        for (int it = 0; it < 6; it++) begin
            for (int w = 0; w < NWORDS; w++) begin
                kind = $urandom_range(0, 3);
                case (kind)
                    1:       set_word(w, $urandom, 1, $urandom_range(0, 31));
                    2:       set_word(w, $urandom, 2, $urandom_range(0, 5));
                    3:       set_word(w, $urandom, 3, $urandom_range(39, 63));
                    default: set_word(w, $urandom, 0, 0);
                endcase
            end
            model_sweep();
            run_sweep($urandom_range(0, 3), 1'b0, ok);
            n_checks++;
            if (!ok || reads !== NWORDS || done_cnt !== 1) begin
                n_fail++; $display("[TB] FAIL rand%0d_sweep: got done=%b reads=%0d pulses=%0d expected 1/4/1", it, ok, reads, done_cnt);
            end
            n_checks++;
            if (corr_count !== 16'(exp_corr) || unc_count !== 16'(exp_unc) || errv_cnt !== exp_errs) begin
                n_fail++; $display("[TB] FAIL rand%0d_counts: got corr=%0d unc=%0d pulses=%0d expected %0d/%0d/%0d",
                                   it, corr_count, unc_count, errv_cnt, exp_corr, exp_unc, exp_errs);
            end
            if (exp_errs > 0) begin
                n_checks++;
                if (err_addr !== ADDR_W'(exp_last_addr) || err_unc !== exp_last_unc) begin
                    n_fail++; $display("[TB] FAIL rand%0d_err_info: got ea=%0d eu=%b expected %0d/%b",
                                       it, err_addr, err_unc, exp_last_addr, exp_last_unc);
                end
            end
            n_checks++;
            if (wr_log.size() != exp_wr.size()) begin
                n_fail++; $display("[TB] FAIL rand%0d_write_count: got %0d expected %0d", it, wr_log.size(), exp_wr.size());
            end else begin
                foreach (exp_wr[i]) begin
                    n_checks++;
                    if (wr_log[i].addr !== exp_wr[i].addr || wr_log[i].d !== exp_wr[i].d || wr_log[i].p !== exp_wr[i].p) begin
                        n_fail++; $display("[TB] FAIL rand%0d_write%0d: got %0d/%h/%h expected %0d/%h/%h", it, i,
                                           wr_log[i].addr, wr_log[i].d, wr_log[i].p, exp_wr[i].addr, exp_wr[i].d, exp_wr[i].p);
                    end
                end
            end
        end
        gnt_random = 1'b0;
    endtask

    initial begin
        int n;
        n = 0;
        for (int q = 3; q <= 38; q++) begin
            if ((q & (q - 1)) != 0) begin
                pos_tab[n] = q;
                n++;
            end
        end
        $display("[TB] ecc_scrubber bench starting");
        test_reset();
        test_clean_sweep();
        test_interval();
        test_data_error();
        test_parity_error();
        test_uncorrectable();
        test_stall();
        test_reset_mid_sweep();
        test_random_sweeps();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ecc_scrubber.md
ECC_SCRUBBER -- requirements
Module: ecc_scrubber

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset, named as follows.
REQ-002 Parameters SHALL be:
- ADDR_W, default 8, word-address width.
- INTERVAL_W, default 16, width of the inter-word delay counter.
REQ-003 Ports SHALL be as follows (name, direction, width, meaning):
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse that begins a full sweep.
- interval  in  INTERVAL_W  idle cycles between words, sampled at start.
- mem_req  out  1  memory request.
- mem_we  out  1  write enable: 1 = write-back, 0 = read.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  corrected data for write-back.
- mem_wpar  out  6  corrected check bits for write-back.
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  read data valid.
- mem_rdata  in  32  read data.
- mem_rpar  in  6  read check bits.
- busy  out  1  sweep in progress.
- done  out  1  one-cycle pulse at sweep end.
- corr_count  out  16  corrected words this sweep, saturating.
- unc_count  out  16  uncorrectable words this sweep, saturating.
- err_valid  out  1  one-cycle pulse per error found.
- err_addr  out  ADDR_W  address of the latest error.
- err_unc  out  1  1 if the latest error is uncorrectable.

Function
REQ-004 Hamming layout SHALL be: positions 1, 2, 4, 8, 16, 32 hold parity[0..5]; positions 3..38, excluding powers of two, hold data[0..31] in ascending order; syndrome bit k is the XOR of parity[k] and every data bit whose position has bit k set.
REQ-005 Decoding SHALL interpret the syndrome as follows:
- 0 = clean.
- Power of two = check-bit error; write back with the parity corrected.
- Other values 3..38 = data error; flip that bit.
- 39..63 = uncorrectable.
REQ-006 The FSM states SHALL be IDLE, RD_REQ, RD_WAIT, CHECK, WR_REQ, GAP, DONE.
REQ-007 In IDLE, start SHALL load addr=0, clear both counters and move to RD_REQ; start SHALL be ignored when not in IDLE.
REQ-008 RD_REQ SHALL hold mem_req=1, mem_we=0 and a stable mem_addr until the cycle mem_gnt=1, then go to RD_WAIT.
REQ-009 RD_WAIT SHALL capture mem_rdata/mem_rpar into a register on mem_rvalid and go to CHECK; mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-010 CHECK SHALL last exactly one cycle using the registered word, and SHALL branch as follows:
- Clean: go to GAP.
- Correctable: pulse err_valid with err_unc=0, increment corr_count, load mem_wdata/mem_wpar, go to WR_REQ.
- Uncorrectable: pulse err_valid with err_unc=1, increment unc_count, go to GAP with no write.
REQ-011 WR_REQ SHALL hold mem_req=1, mem_we=1, mem_addr and the write data stable until mem_gnt=1, then go to GAP.
REQ-012 GAP SHALL count interval cycles (0 = leave the next cycle). It SHALL then go to DONE if addr = 2^ADDR_W-1; otherwise it SHALL increment addr and go to RD_REQ.
REQ-013 DONE SHALL pulse done for one cycle and return to IDLE; the counters and err_* registers SHALL hold until the next start.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 The counters SHALL saturate at 16'hFFFF.
REQ-016 mem_req SHALL be 0 in IDLE, CHECK, GAP and DONE.

Reset
REQ-017 Reset SHALL force IDLE and take priority over every other input, including mid-handshake. Outputs SHALL be zero the following cycle: mem_req, mem_we, mem_addr, mem_wdata, mem_wpar, busy, done, counters, err_valid, err_addr, err_unc.
REQ-018 The address, interval counter and captured word SHALL also reset to 0.

Structure
REQ-019 Widths (32, 6), the syndrome thresholds (38, 63) and the FSM state encodings SHALL live in a shared package/include.
REQ-020 Syndrome computation and correction SHALL be one combinational sub-module, sec_decode (data, parity -> corrected data, corrected parity, syndrome, uncorrectable).

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Clean sweep: ADDR_W=2, interval=0, all words valid, mem_gnt tied 1 -> four reads, zero writes, done once, both counts 0.
- Data error: word 1 has data 32'h0000_0001 with data[0] flipped (syndrome 3) -> write-back of 32'h0000_0001 with the original parity; corr_count=1; err_addr=1, err_unc=0.
- Check-bit error: word 2 has parity[3] flipped (syndrome 8) -> write-back with unchanged data and corrected parity; corr_count=1.
- Uncorrectable: syndrome 45 -> no write; unc_count=1; err_unc=1.
- Stall: mem_gnt held 0 for 5 cycles during RD_REQ and WR_REQ -> mem_req, mem_addr and mem_wdata stay stable throughout, and exactly one transfer occurs.
- Reset mid-sweep: reset in WR_REQ -> next cycle busy=0, mem_req=0, counts 0; a start pulse during busy is ignored.
